// File: rtl/result_buffer_pkg.sv
// Purpose : Shared widths and word layout for the array result/weight buffers.
// Contents: DATA_W/LANES/LANE_W constants, per-lane type and the packed {A,B,C,D} word.
// Usage   : import result_buffer_pkg::*; in every file of the buffer.
package result_buffer_pkg;

  localparam int DATA_W = 32;
  localparam int LANES  = 4;
  localparam int LANE_W = 8;

  typedef logic [LANE_W-1:0] lane_t;

  // Lane A occupies the most significant byte, lane D the least.
  typedef struct packed {
    lane_t a;
    lane_t b;
    lane_t c;
    lane_t d;
  } res_word_t;

  // Number of register stages a lane needs so that all lanes of one word
  // line up with lane D (which arrives last and is used combinationally).
  function automatic int lane_delay(input int lane_idx);
    return (LANES - 1) - lane_idx;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Purpose : Circular word FIFO holding de-skewed results until the DMA takes them.
// Latency : a push at edge N is visible at head_data after edge N; head read combinationally.
// Backpr. : push while full is dropped (drop pulses) unless a pop occurs on the same edge.
// Ports   : axi_clk/axi_rst clock and async reset; push/push_data write side;
//           pop/head_data read side; level/full/empty/drop status.
module result_fifo
  import result_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     axi_clk,
  input  logic                     axi_rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign empty  = (level == '0);
  assign full   = (level == (AW+1)'(DEPTH));
  assign pop_ok = pop && !empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  assign head_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed when level != 0.
  always_ff @(posedge axi_clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/result_buffer.sv
// Purpose : De-skews staggered array result lanes into words and streams them out on AXI4-S.
// Latency : lane A sampled at edge E -> FIFO write at E+3 -> m_axis_valid from the cycle after.
// Backpr. : m_axis_ready low holds the head; words arriving at a full FIFO are dropped, overflow sticks.
// Ports   : axi_clk/axi_rst; in_valid/in_data staggered input; m_axis_* AXI4-S master;
//           buffer_full, overflow (sticky), level (occupancy).
module result_buffer
  import result_buffer_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int PKT_LEN = 16
) (
  input  logic                   axi_clk,
  input  logic                   axi_rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   m_axis_valid,
  output logic [DATA_W-1:0]      m_axis_data,
  output logic                   m_axis_last,
  input  logic                   m_axis_ready,
  output logic                   buffer_full,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int A_DLY  = lane_delay(0);
  localparam int B_DLY  = lane_delay(1);
  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  res_word_t in_w;
  res_word_t aligned;

  logic [A_DLY-1:0][LANE_W-1:0] a_dly;
  logic [B_DLY-1:0][LANE_W-1:0] b_dly;
  lane_t                        c_dly;
  logic [A_DLY-1:0]             vld_dly;

  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic                 fifo_drop;
  logic [BEAT_W-1:0]    beat_cnt;
  logic                 last_beat;

  assign in_w = res_word_t'(in_data);

  // De-skew: every lane is delayed so it lines up with lane D of the same word.
  // in_valid rides alongside lane A, so it gets lane A's delay.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      a_dly   <= '0;
      b_dly   <= '0;
      c_dly   <= '0;
      vld_dly <= '0;
    end else begin
      a_dly   <= {a_dly[A_DLY-2:0], in_w.a};
      b_dly   <= {b_dly[B_DLY-2:0], in_w.b};
      c_dly   <= in_w.c;
      vld_dly <= {vld_dly[A_DLY-2:0], in_valid};
    end
  end

  // Lane D is taken straight from the input on the write edge.
  assign aligned = '{a: a_dly[A_DLY-1], b: b_dly[B_DLY-1], c: c_dly, d: in_w.d};
  assign push    = vld_dly[A_DLY-1];

  assign pop = m_axis_valid && m_axis_ready;

  result_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .axi_clk   (axi_clk),
    .axi_rst   (axi_rst),
    .push      (push),
    .push_data (aligned),
    .pop       (pop),
    .head_data (m_axis_data),
    .level     (level),
    .full      (buffer_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  assign m_axis_valid = !fifo_empty;

  // Beat position within the current packet; advances only on accepted beats,
  // so TLAST stays stable while the DMA stalls.
  assign last_beat = (beat_cnt == BEAT_W'(PKT_LEN - 1));

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + BEAT_W'(1);
    end
  end

  assign m_axis_last = m_axis_valid && last_beat;

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end
  end

endmodule
